// File: rtl/wallace_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wallace_mult_pkg
//  Brief    : Shared state encoding and datapath widths for the shared multiplier
//  Revision : 1.0 - initial release
// ============================================================================
package wallace_mult_pkg;

    localparam int C_OPW  = 4;
    localparam int C_PW   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin arbiter, search starts at last+1
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant
);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(last) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wallace_mult_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : wallace_mult_4x4
//  Brief    : Combinational signed(A) x unsigned(B) 4x4 Wallace-tree multiplier
//  Revision : 1.0 - initial release
// ============================================================================
module wallace_mult_4x4
    import wallace_mult_pkg::*;
(
    input  logic [C_OPW-1:0] i_a,
    input  logic [C_OPW-1:0] i_b,
    output logic [C_PW-1:0]  o_p
);

    logic [C_PW-1:0] w_a_ext;
    logic [C_PW-1:0] w_pp0, w_pp1, w_pp2, w_pp3;
    logic [C_PW-1:0] w_s1, w_c1, w_s2, w_c2;

    // B is unsigned, so every row has positive weight; sign-extending A to full
    // width lets the mod-256 sum come out exact.
    assign w_a_ext = {{(C_PW-C_OPW){i_a[C_OPW-1]}}, i_a};

    assign w_pp0 = i_b[0] ? w_a_ext                  : '0;
    assign w_pp1 = i_b[1] ? {w_a_ext[C_PW-2:0], 1'b0} : '0;
    assign w_pp2 = i_b[2] ? {w_a_ext[C_PW-3:0], 2'b0} : '0;
    assign w_pp3 = i_b[3] ? {w_a_ext[C_PW-4:0], 3'b0} : '0;

    logic [C_PW-1:0] w_m1, w_m2;
    assign w_s1 = w_pp0 ^ w_pp1 ^ w_pp2;
    assign w_m1 = (w_pp0 & w_pp1) | (w_pp0 & w_pp2) | (w_pp1 & w_pp2);
    assign w_c1 = {w_m1[C_PW-2:0], 1'b0};

    assign w_s2 = w_s1 ^ w_c1 ^ w_pp3;
    assign w_m2 = (w_s1 & w_c1) | (w_s1 & w_pp3) | (w_c1 & w_pp3);
    assign w_c2 = {w_m2[C_PW-2:0], 1'b0};

    assign o_p = w_s2 + w_c2;

endmodule
`default_nettype wire

// File: rtl/wallace_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wallace_mult_arbiter
//  Brief    : Round-robin sharing of one 4x4 Wallace multiplier among NREQ clients
//  Revision : 1.0 - initial release
// ============================================================================
module wallace_mult_arbiter
    import wallace_mult_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*C_OPW-1:0] req_a,
    input  logic [NREQ*C_OPW-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [C_PW-1:0]       res_p,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    state_t           r_state;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_id;
    logic [C_OPW-1:0] r_a;
    logic [C_OPW-1:0] r_b;
    logic [C_PW-1:0]  r_res_p;
    logic [IDW-1:0]   r_res_id;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_hs;
    logic [C_PW-1:0]  w_prod;
    logic [C_OPW-1:0] w_a_arr [NREQ];
    logic [C_OPW-1:0] w_b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a_arr[g] = req_a[g*C_OPW +: C_OPW];
        assign w_b_arr[g] = req_b[g*C_OPW +: C_OPW];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    always_comb begin
        w_gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_id = IDW'(i);
            end
        end
    end

    // Grants are only visible while idle so a stalled result blocks new work.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    assign w_hs      = |(req_valid & req_ready);

    wallace_mult_4x4 u_mult (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last   <= IDW'(NREQ-1);
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res_p  <= '0;
            r_res_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_a     <= w_a_arr[w_gnt_id];
                        r_b     <= w_b_arr[w_gnt_id];
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_res_p  <= w_prod;
                    r_res_id <= r_id;
                    r_state  <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign res_valid = (r_state == OUT);
    assign busy      = (r_state != IDLE);
    assign res_p     = r_res_p;
    assign res_id    = r_res_id;

endmodule
`default_nettype wire
